// File: rtl/ptos_serializer.sv
// ptos_serializer: parallel-to-serial symbol transmitter with a one-word holding
// register, idle-symbol fill and a post-reset alignment phase.
module ptos_serializer #(
   parameter int unsigned      WIDTH       = 8,
   parameter logic [WIDTH-1:0] IDLE_SYM    = 8'hBC,
   parameter int unsigned      ALIGN_WORDS = 2,
   parameter bit               LSB_FIRST   = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             out,
   output logic             word_start,
   output logic             out_is_data,
   output logic             aligned
);
   localparam int unsigned     BCW        = $clog2(WIDTH);
   localparam int unsigned     ACW        = (ALIGN_WORDS > 1) ? $clog2(ALIGN_WORDS) : 1;
   localparam logic [BCW-1:0]  BIT_LAST   = BCW'(WIDTH - 1);
   localparam logic [ACW-1:0]  ALIGN_LAST = ACW'(ALIGN_WORDS - 1);

   typedef enum logic {ALIGN, ACTIVE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] shift_reg, hold_reg;
   logic [BCW-1:0]   bit_cnt;
   logic [ACW-1:0]   align_cnt;
   logic             hold_full, sym_is_data;
   logic             boundary, load_data, accept;

   always_comb begin
      boundary  = (bit_cnt == BIT_LAST);
      load_data = boundary && (state == ACTIVE) && hold_full;
      accept    = in_valid && in_ready;
      state_nxt = state;
      if (state == ALIGN && boundary && align_cnt == ALIGN_LAST)
         state_nxt = ACTIVE;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ALIGN;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shift_reg   <= '0;
         hold_reg    <= '0;
         bit_cnt     <= BIT_LAST;
         align_cnt   <= '0;
         hold_full   <= 1'b0;
         sym_is_data <= 1'b0;
      end else begin
         if (boundary) begin
            bit_cnt     <= '0;
            shift_reg   <= load_data ? hold_reg : IDLE_SYM;
            sym_is_data <= load_data;
            if (state == ALIGN)
               align_cnt <= (align_cnt == ALIGN_LAST) ? '0 : align_cnt + ACW'(1);
         end else begin
            bit_cnt   <= bit_cnt + BCW'(1);
            shift_reg <= LSB_FIRST ? (shift_reg >> 1) : (shift_reg << 1);
         end
         // accept needs hold_full low and consume needs it high, so at most one fires
         if (load_data) begin
            hold_full <= 1'b0;
         end else if (accept) begin
            hold_full <= 1'b1;
            hold_reg  <= in;
         end
      end
   end

   // bit_cnt sits at WIDTH-1 until the first boundary, so word_start stays low until then
   assign word_start  = (bit_cnt == '0);
   assign out         = LSB_FIRST ? shift_reg[0] : shift_reg[WIDTH-1];
   assign out_is_data = sym_is_data;
   assign aligned     = (state == ACTIVE);
   assign in_ready    = (state == ACTIVE) && !hold_full;

endmodule

// File: tb/tb_ptos_serializer.sv
// tb_ptos_serializer: checks three serializer configurations against a
// symbol-timeline reference model, plus directed test-plan scenarios.
module tb_ptos_serializer;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        valid_d = 1'b0;
   logic [15:0] word_d = '0;
   logic        rdy_a, out_a, ws_a, isd_a, al_a;
   logic        rdy_b, out_b, ws_b, isd_b, al_b;
   logic        rdy_c, out_c, ws_c, isd_c, al_c;
   logic [4:0]  obs;
   int          sel = 0;
   int          checks = 0;
   int          errors = 0;

   // model: configuration plus state expressed as edges-since-release
   int          m_w, m_aw;
   bit          m_lsb;
   logic [15:0] m_idle, pend_word, cur_sym;
   int          t;
   bit          pend, cur_data;

   always #5 clk = ~clk;

   ptos_serializer #(.WIDTH(8), .IDLE_SYM(8'hBC), .ALIGN_WORDS(2), .LSB_FIRST(1'b0)) dut_a (
      .clk(clk), .reset(reset), .in(word_d[7:0]), .in_valid(valid_d), .in_ready(rdy_a),
      .out(out_a), .word_start(ws_a), .out_is_data(isd_a), .aligned(al_a));

   ptos_serializer #(.WIDTH(8), .IDLE_SYM(8'hBC), .ALIGN_WORDS(2), .LSB_FIRST(1'b1)) dut_b (
      .clk(clk), .reset(reset), .in(word_d[7:0]), .in_valid(valid_d), .in_ready(rdy_b),
      .out(out_b), .word_start(ws_b), .out_is_data(isd_b), .aligned(al_b));

   ptos_serializer #(.WIDTH(10), .IDLE_SYM(10'h17C), .ALIGN_WORDS(1), .LSB_FIRST(1'b0)) dut_c (
      .clk(clk), .reset(reset), .in(word_d[9:0]), .in_valid(valid_d), .in_ready(rdy_c),
      .out(out_c), .word_start(ws_c), .out_is_data(isd_c), .aligned(al_c));

   // obs = {out, word_start, out_is_data, aligned, in_ready} of the selected DUT
   always_comb begin
      case (sel)
         1:       obs = {out_b, ws_b, isd_b, al_b, rdy_b};
         2:       obs = {out_c, ws_c, isd_c, al_c, rdy_c};
         default: obs = {out_a, ws_a, isd_a, al_a, rdy_a};
      endcase
   end

   function automatic logic [4:0] model_outs();
      int   k, p;
      logic o, al;
      if (t == 0) return 5'b0;
      k  = (t - 1) / m_w;
      p  = (t - 1) % m_w;
      o  = m_lsb ? cur_sym[p] : cur_sym[m_w - 1 - p];
      al = (k >= m_aw - 1);
      return {o, (p == 0), cur_data, al, (al && !pend)};
   endfunction

   task automatic model_reset();
      t = 0; pend = 0; cur_data = 0; cur_sym = '0; pend_word = '0;
   endtask

   task automatic model_edge(input bit v, input logic [15:0] w);
      logic [4:0] mo;
      bit         acc;
      mo  = model_outs();
      acc = mo[0] && v;
      t++;
      if ((t - 1) % m_w == 0) begin
         if ((t - 1) / m_w >= m_aw && pend) begin
            cur_sym = pend_word; cur_data = 1; pend = 0;
         end else begin
            cur_sym = m_idle; cur_data = 0;
         end
      end
      if (acc) begin
         pend = 1; pend_word = w;
      end
   endtask

   task automatic configure(input int s);
      sel = s;
      case (s)
         1:       begin m_w = 8;  m_aw = 2; m_lsb = 1; m_idle = 16'h00BC; end
         2:       begin m_w = 10; m_aw = 1; m_lsb = 0; m_idle = 16'h017C; end
         default: begin m_w = 8;  m_aw = 2; m_lsb = 0; m_idle = 16'h00BC; end
      endcase
   endtask

   task automatic start(input int s);
      configure(s);
      valid_d = 0; word_d = '0;
      @(negedge clk); reset = 1; model_reset();
      @(negedge clk); reset = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge(valid_d, word_d);
      #1;
   endtask

   task automatic test_reset();
      configure(0);
      valid_d = 0;
      @(negedge clk); reset = 1; model_reset(); #1;
      checks++;
      if (obs !== 5'b0) begin errors++; $display("FAIL reset_hold: got %b want %b", obs, 5'b0); end
      @(negedge clk); reset = 0; #1;
      checks++;
      if (obs !== 5'b0) begin errors++; $display("FAIL reset_release: got %b want %b", obs, 5'b0); end
   endtask

   task automatic test_idle_align();
      logic [15:0] sym;
      logic        al8, al9;
      start(0);
      sym = '0; al8 = 1'bx; al9 = 1'bx;
      for (int i = 0; i < 32; i++) begin
         tick();
         checks++;
         if (obs !== model_outs()) begin errors++; $display("FAIL idle_model t=%0d: got %b want %b", t, obs, model_outs()); end
         if (t <= 16) sym = {sym[14:0], obs[4]};
         if (t == 8) al8 = obs[1];
         if (t == 9) al9 = obs[1];
      end
      checks++;
      if (sym !== 16'hBCBC) begin errors++; $display("FAIL idle_pattern: got %h want bcbc", sym); end
      checks++;
      if ({al8, al9} !== 2'b01) begin errors++; $display("FAIL align_edge: got %b want 01", {al8, al9}); end
   endtask

   task automatic test_capture();
      logic [15:0] bits;
      int          acc_t;
      bit          rdy_pre, isd17;
      start(0);
      valid_d = 1; word_d = 16'h00A5;
      acc_t = -1; bits = '0; isd17 = 0;
      for (int i = 0; i < 40; i++) begin
         rdy_pre = obs[0];
         tick();
         checks++;
         if (obs !== model_outs()) begin errors++; $display("FAIL capture_model t=%0d: got %b want %b", t, obs, model_outs()); end
         if (rdy_pre && valid_d) begin acc_t = t; valid_d = 0; end
         if (t >= 17 && t <= 32) bits = {bits[14:0], obs[4]};
         if (t == 17) isd17 = obs[2];
      end
      checks++;
      if (acc_t !== 10) begin errors++; $display("FAIL capture_edge: got %0d want 10", acc_t); end
      checks++;
      if (bits !== 16'hA5BC || !isd17) begin errors++; $display("FAIL capture_stream: got %h/%b want a5bc/1", bits, isd17); end
   endtask

   task automatic test_back_to_back();
      logic [7:0]  words [3];
      logic [23:0] cap;
      int          idx, ncap;
      bit          rdy_pre;
      words[0] = 8'hEE; words[1] = 8'hCC; words[2] = 8'hBB;
      start(0);
      idx = 0; ncap = 0; cap = '0;
      valid_d = 1; word_d = {8'h00, words[0]};
      for (int i = 0; i < 60; i++) begin
         rdy_pre = obs[0];
         tick();
         checks++;
         if (obs !== model_outs()) begin errors++; $display("FAIL b2b_model t=%0d: got %b want %b", t, obs, model_outs()); end
         if (rdy_pre && valid_d) begin
            idx++;
            if (idx < 3) word_d = {8'h00, words[idx]};
            else         valid_d = 0;
         end
         if ((ncap > 0 || (obs[3] && obs[2])) && ncap < 24) begin
            cap = {cap[22:0], obs[4]}; ncap++;
         end
      end
      checks++;
      if (cap !== 24'hEECCBB) begin errors++; $display("FAIL b2b_stream: got %h want eeccbb", cap); end
   endtask

   task automatic test_lsb_first();
      logic [7:0] cap;
      int         ncap;
      bit         rdy_pre;
      start(1);
      valid_d = 1; word_d = 16'h00EE; ncap = 0; cap = '0;
      for (int i = 0; i < 40; i++) begin
         rdy_pre = obs[0];
         tick();
         checks++;
         if (obs !== model_outs()) begin errors++; $display("FAIL lsb_model t=%0d: got %b want %b", t, obs, model_outs()); end
         if (rdy_pre && valid_d) valid_d = 0;
         if ((ncap > 0 || (obs[3] && obs[2])) && ncap < 8) begin
            cap = {cap[6:0], obs[4]}; ncap++;
         end
      end
      checks++;
      if (cap !== 8'b01110111) begin errors++; $display("FAIL lsb_stream: got %b want 01110111", cap); end
   endtask

   task automatic test_reset_mid();
      logic [15:0] sym;
      bit          rdy_pre, saw_data;
      start(0);
      valid_d = 1; word_d = 16'h005A;
      for (int i = 0; i < 40 && t < 20; i++) begin
         rdy_pre = obs[0];
         tick();
         checks++;
         if (obs !== model_outs()) begin errors++; $display("FAIL rmid_pre t=%0d: got %b want %b", t, obs, model_outs()); end
         if (rdy_pre && valid_d) begin
            if (word_d == 16'h005A) word_d = 16'h003C;
            else valid_d = 0;
         end
      end
      #2; reset = 1; model_reset(); #1;
      checks++;
      if (obs !== 5'b0) begin errors++; $display("FAIL rmid_async: got %b want %b", obs, 5'b0); end
      valid_d = 0;
      @(negedge clk); reset = 0;
      sym = '0; saw_data = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         checks++;
         if (obs !== model_outs()) begin errors++; $display("FAIL rmid_post t=%0d: got %b want %b", t, obs, model_outs()); end
         if (t <= 16) sym = {sym[14:0], obs[4]};
         if (obs[2]) saw_data = 1;
      end
      checks++;
      if (sym !== 16'hBCBC || saw_data) begin errors++; $display("FAIL rmid_restart: got %h/%b want bcbc/0", sym, saw_data); end
   endtask

   task automatic test_width10();
      logic [9:0] cap;
      int         ncap;
      bit         rdy_pre, al1;
      start(2);
      valid_d = 1; word_d = 16'h02AA; ncap = 0; cap = '0; al1 = 0;
      for (int i = 0; i < 40; i++) begin
         rdy_pre = obs[0];
         tick();
         checks++;
         if (obs !== model_outs()) begin errors++; $display("FAIL w10_model t=%0d: got %b want %b", t, obs, model_outs()); end
         if (rdy_pre && valid_d) valid_d = 0;
         if (t == 1) al1 = obs[1];
         if ((ncap > 0 || (obs[3] && obs[2])) && ncap < 10) begin
            cap = {cap[8:0], obs[4]}; ncap++;
         end
      end
      checks++;
      if (cap !== 10'h2AA || !al1) begin errors++; $display("FAIL w10_stream: got %h/%b want 2aa/1", cap, al1); end
   endtask

   task automatic test_random();
      for (int s = 0; s < 3; s++) begin
         start(s);
         for (int i = 0; i < 300; i++) begin
            valid_d = ($urandom_range(0, 2) != 0);
            word_d  = 16'($urandom);
            tick();
            checks++;
            if (obs !== model_outs()) begin errors++; $display("FAIL random cfg=%0d t=%0d: got %b want %b", s, t, obs, model_outs()); end
         end
      end
   endtask

   initial begin
      m_w = 8; m_aw = 2; m_lsb = 0; m_idle = 16'h00BC;
      model_reset();
      test_reset();
      test_idle_align();
      test_capture();
      test_back_to_back();
      test_lsb_first();
      test_reset_mid();
      test_width10();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
